pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl_pkg.sv | 19 +
 rtl/pipe_hazard_ctrl_if.sv | 46 ++++
 rtl/pipe_hazard_ctrl_fwd_sel.sv | 34 +++
 rtl/pipe_hazard_ctrl.sv | 148 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipe_hazard_ctrl_pkg;

    // Controller state encoding; RUN must be zero so reset lands in normal flow.
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MC_WAIT = 2'd1,
        FLUSH   = 2'd2
    } state_t;

    // Forwarding select value meaning "take the operand from the register file".
    localparam int SEL_RF = 0;

    // Width of the shared MC_WAIT / FLUSH down-counter.
    localparam int DCNT_W = 4;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle of ID-stage, producer-stage and control signals between pipeline and hazard controller.
// Latency: n/a (wiring only).
// Backpressure: n/a; stalls are expressed through pc_we/ir_we/id_bubble.
interface pipe_hazard_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int NSTG   = 3,
    parameter int CNT_W  = 16
);
    localparam int SELW = $clog2(NSTG + 1);

    // ID stage operands
    logic [REG_AW-1:0]      id_rs;
    logic [REG_AW-1:0]      id_rt;
    logic                   id_use_rs;
    logic                   id_use_rt;
    logic                   id_mc;
    // Producer stages after ID, bit/slice k-1 is stage k
    logic [NSTG-1:0]        stg_wreg;
    logic [NSTG*REG_AW-1:0] stg_wn;
    logic [NSTG-1:0]        stg_nrdy;
    logic                   br_taken;
    // Controls back to the pipeline
    logic                   pc_we;
    logic                   ir_we;
    logic                   id_bubble;
    logic                   flush;
    logic [SELW-1:0]        fwd_a;
    logic [SELW-1:0]        fwd_b;
    logic [CNT_W-1:0]       stall_cnt;
    logic [CNT_W-1:0]       flush_cnt;

    // Pipeline side: drives hazard information, consumes controls.
    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt, id_mc,
        output stg_wreg, stg_wn, stg_nrdy, br_taken,
        input  pc_we, ir_we, id_bubble, flush, fwd_a, fwd_b, stall_cnt, flush_cnt
    );

    // Controller side.
    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt, id_mc,
        input  stg_wreg, stg_wn, stg_nrdy, br_taken,
        output pc_we, ir_we, id_bubble, flush, fwd_a, fwd_b, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// Nearest-producer forwarding select for one ID operand, plus its not-ready flag.
// Latency: purely combinational.
// Backpressure: none; nrdy is consumed by the controller to stall ID.
module pipe_fwd_sel
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int NSTG   = 3,
    parameter int SELW   = $clog2(NSTG + 1)
) (
    input  logic [REG_AW-1:0]      reg_n,
    input  logic                   use_reg,
    input  logic [NSTG-1:0]        stg_wreg,
    input  logic [NSTG*REG_AW-1:0] stg_wn,
    input  logic [NSTG-1:0]        stg_nrdy,
    output logic [SELW-1:0]        sel,
    output logic                   nrdy
);

    // Scan oldest to youngest so the smallest matching stage number wins;
    // register 0 is hard-wired and never forwarded.
    always_comb begin
        sel  = SELW'(SEL_RF);
        nrdy = 1'b0;
        for (int k = NSTG; k >= 1; k--) begin
            if (use_reg && (reg_n != '0) && stg_wreg[k-1] &&
                (stg_wn[(k-1)*REG_AW +: REG_AW] == reg_n)) begin
                sel  = SELW'(k);
                nrdy = stg_nrdy[k-1];
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use stall, multi-cycle hold, branch flush.
// Latency: controls are combinational from current state and inputs; state/counters update on clk.
// Backpressure: holds PC and IF/ID via pc_we/ir_we and injects ID bubbles while stalled.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW    = 5,
    parameter int NSTG      = 3,
    parameter int MC_LAT    = 4,
    parameter int FLUSH_CYC = 2,
    parameter int CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    pipe_hazard_ctrl_if.slave  bus
);

    localparam int SELW = $clog2(NSTG + 1);

    state_t              state, state_nxt;
    logic [DCNT_W-1:0]   dcnt, dcnt_nxt;
    logic [CNT_W-1:0]    stall_cnt, flush_cnt;
    logic [SELW-1:0]     sel_a, sel_b;
    logic                nrdy_a, nrdy_b;
    logic                hz_stall;
    logic                pc_we, ir_we, id_bubble, flush;

    pipe_fwd_sel #(.REG_AW(REG_AW), .NSTG(NSTG), .SELW(SELW)) u_fwd_a (
        .reg_n    (bus.id_rs),
        .use_reg  (bus.id_use_rs),
        .stg_wreg (bus.stg_wreg),
        .stg_wn   (bus.stg_wn),
        .stg_nrdy (bus.stg_nrdy),
        .sel      (sel_a),
        .nrdy     (nrdy_a)
    );

    pipe_fwd_sel #(.REG_AW(REG_AW), .NSTG(NSTG), .SELW(SELW)) u_fwd_b (
        .reg_n    (bus.id_rt),
        .use_reg  (bus.id_use_rt),
        .stg_wreg (bus.stg_wreg),
        .stg_wn   (bus.stg_wn),
        .stg_nrdy (bus.stg_nrdy),
        .sel      (sel_b),
        .nrdy     (nrdy_b)
    );

    assign hz_stall = nrdy_a | nrdy_b;

    // Next-state and control decode; reset forces the idle RUN outputs
    // combinationally so nothing leaks out while rst is held.
    always_comb begin
        state_nxt = state;
        dcnt_nxt  = dcnt;
        pc_we     = 1'b1;
        ir_we     = 1'b1;
        id_bubble = 1'b0;
        flush     = 1'b0;
        if (rst) begin
            state_nxt = RUN;
            dcnt_nxt  = '0;
        end else if (bus.br_taken) begin
            // Taken branch wins in every state: kill IF/ID and start the bubble window.
            flush = 1'b1;
            if (FLUSH_CYC > 1) begin
                state_nxt = FLUSH;
                dcnt_nxt  = DCNT_W'(FLUSH_CYC - 1);
            end else begin
                state_nxt = RUN;
                dcnt_nxt  = '0;
            end
        end else begin
            case (state)
                RUN: begin
                    if (hz_stall) begin
                        pc_we     = 1'b0;
                        ir_we     = 1'b0;
                        id_bubble = 1'b1;
                    end else if (bus.id_mc) begin
                        // Op issues this cycle; MC_WAIT covers the remaining MC_LAT-1 cycles.
                        pc_we     = 1'b0;
                        ir_we     = 1'b0;
                        state_nxt = MC_WAIT;
                        dcnt_nxt  = DCNT_W'(MC_LAT - 2);
                    end
                end
                MC_WAIT: begin
                    pc_we     = 1'b0;
                    ir_we     = 1'b0;
                    id_bubble = 1'b1;
                    if (dcnt == '0) begin
                        state_nxt = RUN;
                    end else begin
                        dcnt_nxt = dcnt - 1'b1;
                    end
                end
                FLUSH: begin
                    // Counter holds the number of FLUSH cycles still to run.
                    id_bubble = 1'b1;
                    dcnt_nxt  = (dcnt == '0) ? '0 : dcnt - 1'b1;
                    if (dcnt <= DCNT_W'(1)) begin
                        state_nxt = RUN;
                    end
                end
                default: begin
                    state_nxt = RUN;
                    dcnt_nxt  = '0;
                end
            endcase
        end
    end

    // State and down-counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            dcnt  <= '0;
        end else begin
            state <= state_nxt;
            dcnt  <= dcnt_nxt;
        end
    end

    // Performance counters, wrapping naturally at 2^CNT_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!pc_we) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.pc_we     = pc_we;
    assign bus.ir_we     = ir_we;
    assign bus.id_bubble = id_bubble;
    assign bus.flush     = flush;
    assign bus.fwd_a     = sel_a;
    assign bus.fwd_b     = sel_b;
    assign bus.stall_cnt = stall_cnt;
    assign bus.flush_cnt = flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl.
// Latency: checks combinational controls mid-cycle and counters one edge later.
// Backpressure: n/a.
module tb_pipe_hazard_ctrl;

    localparam int REG_AW = 5;
    localparam int NSTG   = 3;
    localparam int CNT_W  = 16;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   exp_stall;
    int   exp_flush;

    pipe_hazard_ctrl_if #(.REG_AW(REG_AW), .NSTG(NSTG), .CNT_W(CNT_W)) bus ();

    pipe_hazard_ctrl #(
        .REG_AW(REG_AW), .NSTG(NSTG), .MC_LAT(4), .FLUSH_CYC(2), .CNT_W(CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [NSTG*REG_AW-1:0] pack_wn(input int w1, input int w2, input int w3);
        return {REG_AW'(w3), REG_AW'(w2), REG_AW'(w1)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.id_rs     = '0;
        bus.id_rt     = '0;
        bus.id_use_rs = 1'b0;
        bus.id_use_rt = 1'b0;
        bus.id_mc     = 1'b0;
        bus.stg_wreg  = '0;
        bus.stg_wn    = '0;
        bus.stg_nrdy  = '0;
        bus.br_taken  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        tick();
        bus.br_taken = 1'b1; bus.id_mc = 1'b1;
        bus.id_rs = 5'd5; bus.id_use_rs = 1'b1;
        bus.stg_wreg = 3'b001; bus.stg_wn = pack_wn(5, 0, 0); bus.stg_nrdy = 3'b001;
        #1;
        checks++; if (bus.pc_we !== 1'b1)     begin errors++; $display("FAIL rst_pc_we: got %0b want 1", bus.pc_we); end
        checks++; if (bus.ir_we !== 1'b1)     begin errors++; $display("FAIL rst_ir_we: got %0b want 1", bus.ir_we); end
        checks++; if (bus.id_bubble !== 1'b0) begin errors++; $display("FAIL rst_bubble: got %0b want 0", bus.id_bubble); end
        checks++; if (bus.flush !== 1'b0)     begin errors++; $display("FAIL rst_flush: got %0b want 0", bus.flush); end
        checks++; if (bus.fwd_a !== 2'd1)     begin errors++; $display("FAIL rst_fwd_a: got %0d want 1", bus.fwd_a); end
        tick();
        checks++; if (bus.stall_cnt !== 16'd0) begin errors++; $display("FAIL rst_stall_cnt: got %0d want 0", bus.stall_cnt); end
        checks++; if (bus.flush_cnt !== 16'd0) begin errors++; $display("FAIL rst_flush_cnt: got %0d want 0", bus.flush_cnt); end
        idle();
        rst = 1'b0;
        exp_stall = 0; exp_flush = 0;
        #1;
        checks++; if (bus.pc_we !== 1'b1) begin errors++; $display("FAIL rst_release_pc_we: got %0b want 1", bus.pc_we); end
        tick();
    endtask

    task automatic test_fwd_priority();
        idle();
        bus.id_rs = 5'd3; bus.id_use_rs = 1'b1;
        bus.stg_wreg = 3'b011; bus.stg_wn = pack_wn(3, 3, 0);
        #1;
        checks++; if (bus.fwd_a !== 2'd1) begin errors++; $display("FAIL fwd_youngest: got %0d want 1", bus.fwd_a); end
        bus.stg_wreg = 3'b110; bus.stg_wn = pack_wn(3, 3, 3);
        #1;
        checks++; if (bus.fwd_a !== 2'd2) begin errors++; $display("FAIL fwd_skip_nowrite: got %0d want 2", bus.fwd_a); end
        bus.stg_wreg = 3'b100; bus.id_rt = 5'd3; bus.id_use_rt = 1'b1;
        #1;
        checks++; if (bus.fwd_a !== 2'd3) begin errors++; $display("FAIL fwd_a_wb: got %0d want 3", bus.fwd_a); end
        checks++; if (bus.fwd_b !== 2'd3) begin errors++; $display("FAIL fwd_b_wb: got %0d want 3", bus.fwd_b); end
        bus.id_use_rs = 1'b0; bus.stg_wn = pack_wn(3, 3, 9);
        #1;
        checks++; if (bus.fwd_a !== 2'd0) begin errors++; $display("FAIL fwd_unused: got %0d want 0", bus.fwd_a); end
        checks++; if (bus.fwd_b !== 2'd0) begin errors++; $display("FAIL fwd_b_nomatch: got %0d want 0", bus.fwd_b); end
        tick();
        idle();
    endtask

    task automatic test_zero_reg();
        idle();
        bus.id_rt = 5'd0; bus.id_use_rt = 1'b1;
        bus.stg_wreg = 3'b001; bus.stg_wn = pack_wn(0, 0, 0); bus.stg_nrdy = 3'b001;
        #1;
        checks++; if (bus.fwd_b !== 2'd0) begin errors++; $display("FAIL zero_fwd_b: got %0d want 0", bus.fwd_b); end
        checks++; if (bus.pc_we !== 1'b1) begin errors++; $display("FAIL zero_no_stall: got %0b want 1", bus.pc_we); end
        tick();
        checks++; if (bus.stall_cnt !== 16'(exp_stall)) begin errors++; $display("FAIL zero_stall_cnt: got %0d want %0d", bus.stall_cnt, exp_stall); end
        idle();
    endtask

    task automatic test_load_use();
        idle();
        bus.id_rs = 5'd5; bus.id_use_rs = 1'b1;
        bus.stg_wreg = 3'b001; bus.stg_wn = pack_wn(5, 0, 0); bus.stg_nrdy = 3'b001;
        #1;
        checks++; if (bus.pc_we !== 1'b0)     begin errors++; $display("FAIL lu_pc_we: got %0b want 0", bus.pc_we); end
        checks++; if (bus.ir_we !== 1'b0)     begin errors++; $display("FAIL lu_ir_we: got %0b want 0", bus.ir_we); end
        checks++; if (bus.id_bubble !== 1'b1) begin errors++; $display("FAIL lu_bubble: got %0b want 1", bus.id_bubble); end
        tick();
        exp_stall++;
        checks++; if (bus.stall_cnt !== 16'(exp_stall)) begin errors++; $display("FAIL lu_stall_cnt: got %0d want %0d", bus.stall_cnt, exp_stall); end
        bus.stg_wreg = 3'b010; bus.stg_wn = pack_wn(0, 5, 0); bus.stg_nrdy = 3'b000;
        #1;
        checks++; if (bus.fwd_a !== 2'd2)     begin errors++; $display("FAIL lu_fwd_mem: got %0d want 2", bus.fwd_a); end
        checks++; if (bus.pc_we !== 1'b1)     begin errors++; $display("FAIL lu_resume: got %0b want 1", bus.pc_we); end
        checks++; if (bus.id_bubble !== 1'b0) begin errors++; $display("FAIL lu_resume_bubble: got %0b want 0", bus.id_bubble); end
        tick();
        checks++; if (bus.stall_cnt !== 16'(exp_stall)) begin errors++; $display("FAIL lu_stall_hold: got %0d want %0d", bus.stall_cnt, exp_stall); end
        idle();
    endtask

    task automatic test_multicycle();
        idle();
        bus.id_mc = 1'b1;
        #1;
        checks++; if (bus.pc_we !== 1'b0)     begin errors++; $display("FAIL mc_issue_pc_we: got %0b want 0", bus.pc_we); end
        checks++; if (bus.id_bubble !== 1'b0) begin errors++; $display("FAIL mc_issue_bubble: got %0b want 0", bus.id_bubble); end
        tick();
        bus.id_mc = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (bus.pc_we !== 1'b0)     begin errors++; $display("FAIL mc_wait%0d_pc_we: got %0b want 0", i, bus.pc_we); end
            checks++; if (bus.id_bubble !== 1'b1) begin errors++; $display("FAIL mc_wait%0d_bubble: got %0b want 1", i, bus.id_bubble); end
            tick();
        end
        exp_stall += 4;
        #1;
        checks++; if (bus.pc_we !== 1'b1)     begin errors++; $display("FAIL mc_done_pc_we: got %0b want 1", bus.pc_we); end
        checks++; if (bus.id_bubble !== 1'b0) begin errors++; $display("FAIL mc_done_bubble: got %0b want 0", bus.id_bubble); end
        checks++; if (bus.stall_cnt !== 16'(exp_stall)) begin errors++; $display("FAIL mc_stall_cnt: got %0d want %0d", bus.stall_cnt, exp_stall); end
        tick();
    endtask

    task automatic test_branch_in_mc();
        idle();
        bus.id_mc = 1'b1;
        #1;
        tick();
        bus.id_mc = 1'b0;
        #1;
        checks++; if (bus.id_bubble !== 1'b1) begin errors++; $display("FAIL bmc_wait1_bubble: got %0b want 1", bus.id_bubble); end
        tick();
        bus.br_taken = 1'b1;
        #1;
        checks++; if (bus.flush !== 1'b1) begin errors++; $display("FAIL bmc_flush: got %0b want 1", bus.flush); end
        checks++; if (bus.pc_we !== 1'b1) begin errors++; $display("FAIL bmc_pc_we: got %0b want 1", bus.pc_we); end
        tick();
        exp_flush++; exp_stall += 2;
        bus.br_taken = 1'b0;
        #1;
        checks++; if (bus.flush !== 1'b0)     begin errors++; $display("FAIL bmc_fl_flush: got %0b want 0", bus.flush); end
        checks++; if (bus.id_bubble !== 1'b1) begin errors++; $display("FAIL bmc_fl_bubble: got %0b want 1", bus.id_bubble); end
        checks++; if (bus.pc_we !== 1'b1)     begin errors++; $display("FAIL bmc_fl_pc_we: got %0b want 1", bus.pc_we); end
        checks++; if (bus.flush_cnt !== 16'(exp_flush)) begin errors++; $display("FAIL bmc_flush_cnt: got %0d want %0d", bus.flush_cnt, exp_flush); end
        tick();
        #1;
        checks++; if (bus.id_bubble !== 1'b0) begin errors++; $display("FAIL bmc_run_bubble: got %0b want 0", bus.id_bubble); end
        checks++; if (bus.stall_cnt !== 16'(exp_stall)) begin errors++; $display("FAIL bmc_stall_cnt: got %0d want %0d", bus.stall_cnt, exp_stall); end
        tick();
    endtask

    task automatic test_back_to_back();
        idle();
        bus.br_taken = 1'b1;
        #1;
        checks++; if (bus.flush !== 1'b1) begin errors++; $display("FAIL b2b_first: got %0b want 1", bus.flush); end
        tick();
        #1;
        checks++; if (bus.flush !== 1'b1)     begin errors++; $display("FAIL b2b_second: got %0b want 1", bus.flush); end
        checks++; if (bus.id_bubble !== 1'b0) begin errors++; $display("FAIL b2b_second_bubble: got %0b want 0", bus.id_bubble); end
        tick();
        exp_flush += 2;
        bus.br_taken = 1'b0;
        #1;
        checks++; if (bus.id_bubble !== 1'b1) begin errors++; $display("FAIL b2b_fl_bubble: got %0b want 1", bus.id_bubble); end
        tick();
        #1;
        checks++; if (bus.id_bubble !== 1'b0) begin errors++; $display("FAIL b2b_run_bubble: got %0b want 0", bus.id_bubble); end
        checks++; if (bus.flush_cnt !== 16'(exp_flush)) begin errors++; $display("FAIL b2b_flush_cnt: got %0d want %0d", bus.flush_cnt, exp_flush); end
        tick();
    endtask

    task automatic test_reset_mid_flush();
        idle();
        bus.br_taken = 1'b1;
        #1;
        tick();
        bus.br_taken = 1'b0;
        #1;
        checks++; if (bus.id_bubble !== 1'b1) begin errors++; $display("FAIL rf_in_flush: got %0b want 1", bus.id_bubble); end
        rst = 1'b1;
        #1;
        exp_stall = 0; exp_flush = 0;
        checks++; if (bus.id_bubble !== 1'b0)  begin errors++; $display("FAIL rf_bubble: got %0b want 0", bus.id_bubble); end
        checks++; if (bus.pc_we !== 1'b1)      begin errors++; $display("FAIL rf_pc_we: got %0b want 1", bus.pc_we); end
        checks++; if (bus.stall_cnt !== 16'd0) begin errors++; $display("FAIL rf_stall_cnt: got %0d want 0", bus.stall_cnt); end
        checks++; if (bus.flush_cnt !== 16'd0) begin errors++; $display("FAIL rf_flush_cnt: got %0d want 0", bus.flush_cnt); end
        tick();
        rst = 1'b0;
        #1;
        checks++; if (bus.id_bubble !== 1'b0) begin errors++; $display("FAIL rf_release_bubble: got %0b want 0", bus.id_bubble); end
        tick();
        checks++; if (bus.id_bubble !== 1'b0) begin errors++; $display("FAIL rf_run_bubble: got %0b want 0", bus.id_bubble); end
    endtask

    task automatic test_reset_mid_mc();
        idle();
        bus.id_mc = 1'b1;
        #1;
        tick();
        bus.id_mc = 1'b0;
        #1;
        checks++; if (bus.pc_we !== 1'b0) begin errors++; $display("FAIL rm_in_wait: got %0b want 0", bus.pc_we); end
        rst = 1'b1;
        #1;
        checks++; if (bus.pc_we !== 1'b1)     begin errors++; $display("FAIL rm_pc_we: got %0b want 1", bus.pc_we); end
        checks++; if (bus.ir_we !== 1'b1)     begin errors++; $display("FAIL rm_ir_we: got %0b want 1", bus.ir_we); end
        checks++; if (bus.id_bubble !== 1'b0) begin errors++; $display("FAIL rm_bubble: got %0b want 0", bus.id_bubble); end
        tick();
        rst = 1'b0;
        #1;
        tick();
        checks++; if (bus.pc_we !== 1'b1)      begin errors++; $display("FAIL rm_no_residual: got %0b want 1", bus.pc_we); end
        checks++; if (bus.stall_cnt !== 16'd0) begin errors++; $display("FAIL rm_stall_cnt: got %0d want 0", bus.stall_cnt); end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        exp_stall = 0;
        exp_flush = 0;
        rst       = 1'b1;
        idle();
        test_reset();
        test_fwd_priority();
        test_zero_reg();
        test_load_use();
        test_multicycle();
        test_branch_in_mc();
        test_back_to_back();
        test_reset_mid_flush();
        test_reset_mid_mc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
